// File: rtl/bldc_drive_ctrl.sv
// bldc_drive_ctrl: hall filter, PWM/direction sequencing, coast-before-reverse,
// illegal-hall fault latch and hall-edge speed measurement for a BLDC stage.
// Ports: clk, rst_n (async, active low), enable, cmd_mag/cmd_dir/cmd_valid/
//   cmd_ready (command handshake), h_raw (raw halls {h3,h2,h1}),
//   h1/h2/h3 (filtered halls), p (PWM), sign (direction), fault (latched),
//   speed/speed_valid (hall edges per SPEED_WIN window, one-cycle update pulse).
// Optional: `define STALL_DET_EN adds a stall timeout (STALL_CYC) into FAULT.
module bldc_drive_ctrl #(
  parameter int PWM_BITS     = 8,
  parameter int DEBOUNCE_CYC = 4,
  parameter int COAST_CYC    = 1000,
  parameter int RAMP_STEP    = 1,
  parameter int SPEED_WIN    = 100000
`ifdef STALL_DET_EN
  ,
  parameter int STALL_CYC    = 2000000
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] cmd_mag,
  input  logic                cmd_dir,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          h_raw,
  output logic                h1,
  output logic                h2,
  output logic                h3,
  output logic                p,
  output logic                sign,
  output logic                fault,
  output logic [15:0]         speed,
  output logic                speed_valid
);

  localparam int DBW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int CW  = $clog2(COAST_CYC + 1);
  localparam int WW  = $clog2(SPEED_WIN);

  localparam logic [DBW-1:0] DEB_LAST = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0]  CLOAD    = CW'(COAST_CYC - 1);
  localparam logic [WW-1:0]  WLAST    = WW'(SPEED_WIN - 1);

  localparam logic [PWM_BITS-1:0] PMAX =
    {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(RAMP_STEP);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    COAST,
    FAULT
  } state_t;

  state_t state;

  // Hall synchroniser and debounce
  logic [2:0]     s1, s2, cand, filt;
  logic [DBW-1:0] db_cnt;
  logic           db_stable;
  logic           hall_edge;
  logic           hall_bad;

  // db_cnt counts earlier cycles in which s2 already equalled cand;
  // s2 is accepted on its DEBOUNCE_CYC-th identical cycle.
  assign db_stable = (s2 == cand) && (db_cnt == DEB_LAST);
  assign hall_edge = db_stable && (cand != filt);
  assign hall_bad  = (filt == 3'b000) || (filt == 3'b111);
  assign {h3, h2, h1} = filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      s2     <= '0;
      cand   <= '0;
      filt   <= '0;
      db_cnt <= '0;
    end else begin
      s1 <= h_raw;
      s2 <= s1;
      if (s2 != cand) begin
        cand   <= s2;
        db_cnt <= DBW'(1);
      end else if (db_cnt != DEB_LAST) begin
        db_cnt <= db_cnt + 1'b1;
      end
      if (db_stable) filt <= cand;
    end
  end

  // PWM and ramp
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_cur;
  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] duty_ramp;
  logic                wrap;

  assign wrap = (pwm_cnt == PMAX);

  always_comb begin
    duty_ramp = duty_cur;
    if (target > duty_cur) begin
      if ((target - duty_cur) > STEP) duty_ramp = duty_cur + STEP;
      else                            duty_ramp = target;
    end else if (target < duty_cur) begin
      if ((duty_cur - target) > STEP) duty_ramp = duty_cur - STEP;
      else                            duty_ramp = target;
    end
  end

`ifdef STALL_DET_EN
  localparam int SW = $clog2(STALL_CYC + 1);
  localparam logic [SW-1:0] SLAST = SW'(STALL_CYC);
  localparam logic [PWM_BITS-1:0] DTH =
    PWM_BITS'(1) << (PWM_BITS - 2);

  logic [SW-1:0] stall_cnt;
  logic          stall_hit;

  assign stall_hit = (stall_cnt == SLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state != RUN || hall_edge || duty_cur < DTH) begin
      stall_cnt <= '0;
    end else if (!stall_hit) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  logic stall_hit;
  assign stall_hit = 1'b0;
`endif

  // Sequencing FSM
  logic          trip;
  logic          accept;
  logic          pend_dir;
  logic [CW-1:0] coast_cnt;

  assign trip      = hall_bad || stall_hit;
  assign cmd_ready = (state == IDLE) || (state == RUN);
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pwm_cnt   <= '0;
      duty_cur  <= '0;
      target    <= '0;
      pend_dir  <= 1'b0;
      coast_cnt <= '0;
      p         <= 1'b0;
      sign      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      pwm_cnt <= wrap ? '0 : pwm_cnt + 1'b1;
      p       <= (state == RUN) && (pwm_cnt < duty_cur);
      unique case (state)
        IDLE: begin
          duty_cur <= '0;
          if (accept) begin
            target   <= cmd_mag;
            sign     <= cmd_dir;
            pend_dir <= cmd_dir;
          end
          if (enable) state <= RUN;
        end
        RUN: begin
          if (!enable) begin
            state     <= IDLE;
            duty_cur  <= '0;
            target    <= '0;
            coast_cnt <= '0;
            p         <= 1'b0;
          end else if (trip) begin
            state    <= FAULT;
            fault    <= 1'b1;
            duty_cur <= '0;
            target   <= '0;
            p        <= 1'b0;
          end else begin
            if (wrap) duty_cur <= duty_ramp;
            if (accept) begin
              target   <= cmd_mag;
              pend_dir <= cmd_dir;
              if (cmd_dir != sign) begin
                if (duty_cur == '0) begin
                  sign <= cmd_dir;
                end else begin
                  // reversing under load: drop drive, coast first
                  duty_cur  <= '0;
                  p         <= 1'b0;
                  coast_cnt <= CLOAD;
                  state     <= COAST;
                end
              end
            end
          end
        end
        COAST: begin
          duty_cur <= '0;
          if (!enable) begin
            state     <= IDLE;
            target    <= '0;
            coast_cnt <= '0;
          end else if (trip) begin
            state  <= FAULT;
            fault  <= 1'b1;
            target <= '0;
          end else if (coast_cnt == '0) begin
            sign  <= pend_dir;
            state <= RUN;
          end else begin
            coast_cnt <= coast_cnt - 1'b1;
          end
        end
        FAULT: begin
          duty_cur <= '0;
          target   <= '0;
          if (!enable) begin
            state <= IDLE;
            fault <= 1'b0;
          end
        end
      endcase
    end
  end

  // Speed window
  logic [WW-1:0] win_cnt;
  logic [15:0]   edge_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt     <= '0;
      edge_cnt    <= '0;
      speed       <= '0;
      speed_valid <= 1'b0;
    end else if (win_cnt == WLAST) begin
      win_cnt     <= '0;
      speed       <= edge_cnt;
      speed_valid <= 1'b1;
      edge_cnt    <= hall_edge ? 16'd1 : 16'd0;
    end else begin
      win_cnt     <= win_cnt + 1'b1;
      speed_valid <= 1'b0;
      if (hall_edge && edge_cnt != 16'hFFFF) edge_cnt <= edge_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bldc_drive_ctrl.sv
// tb_bldc_drive_ctrl: scoreboard bench for bldc_drive_ctrl
// (ramp, reversal coast, debounce, speed, illegal hall, async reset).
`timescale 1ns/1ps
module tb_bldc_drive_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  cmd_mag = '0;
  logic        cmd_dir = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  h_raw = 3'b001;
  logic        h1, h2, h3;
  logic        p, sign, fault;
  logic [15:0] speed;
  logic        speed_valid;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  logic [2:0] seq [10] = '{3'b010, 3'b110, 3'b100, 3'b101, 3'b001,
                           3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bldc_drive_ctrl #(
    .PWM_BITS(8),
    .DEBOUNCE_CYC(4),
    .COAST_CYC(20),
    .RAMP_STEP(1),
    .SPEED_WIN(1000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .cmd_mag(cmd_mag),
    .cmd_dir(cmd_dir),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .h_raw(h_raw),
    .h1(h1),
    .h2(h2),
    .h3(h3),
    .p(p),
    .sign(sign),
    .fault(fault),
    .speed(speed),
    .speed_valid(speed_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic pop_chk(input logic [31:0] got);
    if (exp_q.size() == 0) chk("sb_empty", exp_q.size(), 1);
    else chk(tag_q.pop_front(), got, exp_q.pop_front());
  endtask

  // next rising edge of p: width in cycles and cycle stamp of the rise
  task automatic get_pulse(input string tag, output int w, output int t);
    logic prev;
    bit   seen;
    seen = 1'b0;
    w = 0;
    t = 0;
    @(negedge clk);
    prev = p;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (p && !prev) begin
        seen = 1'b1;
        break;
      end
      prev = p;
    end
    if (!seen) begin
      chk({tag, "_tmo"}, seen, 1);
      return;
    end
    t = cyc;
    w = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!p) break;
      w++;
    end
  endtask

  task automatic wait_sv(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (speed_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({tag, "_tmo"}, seen, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    int w1, w2, t1, t2, viol, chg;
    logic sgn_mid, rdy_end, sgn_end, pre_h, post_h;

    // reset values
    repeat (2) @(negedge clk);
    push("rst_p", 0);
    push("rst_sign", 0);
    push("rst_fault", 0);
    push("rst_hall", 0);
    push("rst_speed", 0);
    push("rst_sv", 0);
    push("rst_ready", 1);
    pop_chk(p);
    pop_chk(sign);
    pop_chk(fault);
    pop_chk({h3, h2, h1});
    pop_chk(speed);
    pop_chk(speed_valid);
    pop_chk(cmd_ready);

    rst_n = 1'b1;
    push("hall_init", 1);
    repeat (10) @(negedge clk);
    pop_chk({h3, h2, h1});

    // duty ramp to 64
    push("ramp_w1", 1);
    push("ramp_w2", 2);
    push("ramp_per", 255);
    push("duty64_a", 64);
    push("duty64_b", 64);
    push("per64", 255);
    enable = 1'b1;
    cmd_valid = 1'b1;
    cmd_mag = 8'd64;
    cmd_dir = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    get_pulse("r1", w1, t1);
    get_pulse("r2", w2, t2);
    pop_chk(w1);
    pop_chk(w2);
    pop_chk(t2 - t1);
    repeat (70 * 255) @(negedge clk);
    get_pulse("d64a", w1, t1);
    get_pulse("d64b", w2, t2);
    pop_chk(w1);
    pop_chk(w2);
    pop_chk(t2 - t1);

    // reversal with coast; a command held during coast must be ignored
    push("coast_viol", 0);
    push("coast_sign", 0);
    push("coast_end_rdy", 1);
    push("coast_end_sign", 1);
    push("rev_w1", 1);
    push("rev32_a", 32);
    push("rev32_b", 32);
    push("rev_sign", 1);
    cmd_valid = 1'b1;
    cmd_dir = 1'b1;
    cmd_mag = 8'd32;
    @(negedge clk);
    cmd_valid = 1'b0;
    viol = 0;
    sgn_mid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      if (p || cmd_ready) viol++;
      if (i == 10) sgn_mid = sign;
      if (i == 5) begin
        cmd_valid = 1'b1;
        cmd_dir = 1'b0;
        cmd_mag = 8'd200;
      end
      if (i == 15) cmd_valid = 1'b0;
    end
    @(negedge clk);
    rdy_end = cmd_ready;
    sgn_end = sign;
    pop_chk(viol);
    pop_chk(sgn_mid);
    pop_chk(rdy_end);
    pop_chk(sgn_end);
    get_pulse("rev1", w1, t1);
    pop_chk(w1);
    repeat (40 * 255) @(negedge clk);
    get_pulse("r32a", w1, t1);
    get_pulse("r32b", w2, t2);
    pop_chk(w1);
    pop_chk(w2);
    pop_chk(sign);

    // debounce: 3-cycle glitch rejected, 4-cycle hold accepted at +6
    push("glitch", 0);
    push("db_pre", 1);
    push("db_post", 3);
    h_raw = 3'b011;
    repeat (3) @(negedge clk);
    h_raw = 3'b001;
    chg = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ({h3, h2, h1} != 3'b001) chg++;
    end
    pop_chk(chg);
    h_raw = 3'b011;
    repeat (5) @(negedge clk);
    pre_h = ({h3, h2, h1} == 3'b001);
    @(negedge clk);
    post_h = ({h3, h2, h1} == 3'b011);
    pop_chk(pre_h ? 1 : 0);
    pop_chk(post_h ? 3 : 0);

    // speed: 10 legal edges inside one window
    wait_sv("sv1");
    push("speed", 10);
    push("sv_pulse", 0);
    for (int i = 0; i < 10; i++) begin
      h_raw = seq[i];
      repeat (20) @(negedge clk);
    end
    wait_sv("sv2");
    pop_chk(speed);
    @(negedge clk);
    pop_chk(speed_valid);

    // illegal hall
    push("flt_pre", 0);
    push("flt_set", 1);
    push("flt_p", 0);
    push("flt_rdy", 0);
    push("flt_p_hold", 0);
    push("flt_clr", 0);
    push("flt_rdy2", 1);
    push("flt_sign", 1);
    h_raw = 3'b111;
    repeat (6) @(negedge clk);
    pop_chk(fault);
    @(negedge clk);
    pop_chk(fault);
    pop_chk(p);
    pop_chk(cmd_ready);
    chg = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (p) chg++;
    end
    pop_chk(chg);
    enable = 1'b0;
    @(negedge clk);
    pop_chk(fault);
    pop_chk(cmd_ready);
    pop_chk(sign);
    h_raw = 3'b001;
    repeat (10) @(negedge clk);

    // IDLE commands set sign directly
    push("idle_sign0", 0);
    push("idle_sign1", 1);
    cmd_valid = 1'b1;
    cmd_dir = 1'b0;
    cmd_mag = 8'd10;
    @(negedge clk);
    pop_chk(sign);
    cmd_dir = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    pop_chk(sign);
    repeat (3 * 255) @(negedge clk);

    // async reset mid-coast
    push("coast_rdy", 0);
    push("coast_sign1", 1);
    push("ar_p", 0);
    push("ar_sign", 0);
    push("ar_fault", 0);
    push("ar_speed", 0);
    push("ar_rdy", 1);
    push("post_rdy", 1);
    push("post_p", 0);
    cmd_valid = 1'b1;
    cmd_dir = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    pop_chk(cmd_ready);
    pop_chk(sign);
    #2;
    rst_n = 1'b0;
    #1;
    pop_chk(p);
    pop_chk(sign);
    pop_chk(fault);
    pop_chk(speed);
    pop_chk(cmd_ready);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pop_chk(cmd_ready);
    pop_chk(p);

    chk("sb_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
